perf_counter_unit: RTL and testbench
====================================

# perf_counter_unit

Synthesizable performance-monitor block for the N-way superscalar MIPS core. Counts cycles, issued instructions, resolved branches, mispredictions, flushes and hazard stalls across `LANES` issue lanes. Values are frozen into a shadow bank on request and read out one event at a time. It sits beside the top-level pipeline, fed by per-lane EX-stage and hazard-unit signals, and replaces ad-hoc bench-side counting.

## Interface
- `LANES`, 2: issue width; per-lane inputs are `LANES` bits wide.
- `CNT_W`, 64: width of every counter and of `rd_data`; legal range 8..64.
- `clk`  in  1: sole clock, rising edge.
- `Reset`  in  1: synchronous, active-high reset.
- `count_en`  in  1: when high, counters accumulate.
- `clear`  in  1: synchronous zero of live counters and `ovf`.
- `inst_valid`  in  LANES: lane i issued a non-zero instruction this cycle.
- `branch_ex`  in  LANES: lane i has a branch resolving in EX.
- `false_taken`  in  LANES: lane i predicted taken, was not taken.
- `false_not_taken`  in  LANES: lane i predicted not-taken, was taken.
- `flush`  in  1: pipeline flush this cycle.
- `stall`  in  1: hazard stall this cycle.
- `snap_req`  in  1: copy all live counters into the shadow bank.
- `rd_en`  in  1: read request.
- `rd_sel`  in  3: event index to read.
- `rd_data`  out  CNT_W: shadow value of the selected event.
- `rd_valid`  out  1: `rd_data` is valid this cycle.
- `ovf`  out  6: sticky overflow flag per event.
- `snap_valid`  out  1: at least one snapshot has been taken since reset.

## Operation
- Event indices: 0 cycles, 1 instructions, 2 branches, 3 mispredicts, 4 flushes, 5 stalls.
- Per-cycle increments while `count_en`=1:
  - cycles +1.
  - instructions +popcount(`inst_valid`).
  - branches +popcount(`branch_ex`).
  - mispredicts +popcount(`branch_ex` & (`false_taken` | `false_not_taken`)). A mispredict bit without its `branch_ex` bit is ignored.
  - flushes +`flush`.
  - stalls +`stall`.
- Increment width is clog2(`LANES`+1). The increment is zero-extended to `CNT_W`.
- `count_en`=0: counters hold. `clear`, snapshot and read still operate.
- Priority for live counters: `Reset` > `clear` > increment.
- Snapshot: on `snap_req`, the shadow bank takes the live register values present at that edge, i.e. excluding that cycle's increments. `snap_valid` sets and stays set.
- Read: `rd_en` at edge t gives `rd_data` = shadow[`rd_sel`] and `rd_valid`=1 during cycle t+1.
  - `rd_sel` ≥ 6 returns 0, still with `rd_valid`=1.
  - `rd_valid` is 0 in any cycle after a cycle with `rd_en`=0.
  - `rd_data` holds its last value while `rd_valid`=0.
- Simultaneous `snap_req` and `rd_en`: the read returns the pre-snapshot shadow value.
- Simultaneous `clear` and `snap_req`: the shadow captures the pre-clear values.
- `ovf[k]` sets when counter k would exceed 2^CNT_W−1. It is cleared only by `Reset` or `clear`.

## Timing
- Reset values: all live counters, shadow bank, `ovf`, `rd_data`, `rd_valid`, `snap_valid` = 0.
- Live counter reflects an event at the edge following the event cycle.
- Snapshot-to-readable latency: a `rd_en` issued 1 cycle after `snap_req` returns the new value.
- Read latency: 1 cycle, fully pipelined; one read per cycle.
- `Reset` asserted mid-operation zeroes everything at that edge; a pending read is dropped (`rd_valid`=0 next cycle).

## Configuration
- `PERF_SAT_EN` defined: on overflow a counter saturates at all-ones and holds; `ovf` sets.
- `PERF_SAT_EN` undefined: counters wrap modulo 2^CNT_W, keeping the low bits of the sum; `ovf` sets on wrap.

## Structure
- Package `perf_pkg`:
  - event index constants `EV_CYCLES`..`EV_STALLS`.
  - `NUM_EV`=6.
  - `RD_SEL_W`=3.
  - popcount function.
- Sub-module `perf_ctr`: one `CNT_W`-bit counter with increment input, clear, saturate/wrap logic and sticky overflow. Instantiated `NUM_EV` times.
- Top level holds the increment logic, shadow bank and read register.

## Test plan
- Reset released, `count_en`=1 for 10 cycles, all events 0, `snap_req`, read index 0 → `rd_data`=10, other indices 0, `snap_valid`=1.
- `LANES`=2: `inst_valid`=2'b11 for 3 cycles, then 2'b01 for 2 cycles → instructions=8.
- `branch_ex`=2'b10 with `false_taken`=2'b11 for 4 cycles → branches=4, mispredicts=4. `false_taken`=2'b01 with `branch_ex`=0 → mispredicts unchanged.
- `CNT_W`=8, `stall`=1 for 260 cycles → with `PERF_SAT_EN`: stalls=255, `ovf[5]`=1. Without it: stalls=4, `ovf[5]`=1.
- `clear` and `snap_req` in the same cycle, with cycles=50 → shadow cycles=50, live cycles=0, `ovf`=0. A read in that same cycle returns the previous shadow value.
- `rd_en` with `rd_sel`=7 → `rd_data`=0, `rd_valid`=1. `Reset` asserted during a read → `rd_valid`=0 and all outputs 0 next cycle.

Source files
------------

// File: rtl/perf_pkg.sv
// Shared constants and helpers for the performance-counter unit.
package perf_pkg;
   localparam int unsigned NUM_EV     = 6;
   localparam int unsigned RD_SEL_W   = 3;
   localparam int unsigned EV_CYCLES  = 0;
   localparam int unsigned EV_INSTS   = 1;
   localparam int unsigned EV_BRANCH  = 2;
   localparam int unsigned EV_MISPRED = 3;
   localparam int unsigned EV_FLUSH   = 4;
   localparam int unsigned EV_STALLS  = 5;
   localparam int unsigned MAX_LANES  = 32;
   localparam int unsigned PC_W       = 6;

   function automatic logic [PC_W-1:0] popcount(input logic [MAX_LANES-1:0] v);
      logic [PC_W-1:0] n;
      n = '0;
      for (int unsigned i = 0; i < MAX_LANES; i++) begin
         n = n + PC_W'(v[i]);
      end
      return n;
   endfunction
endpackage

// File: rtl/perf_counter_unit_ctr.sv
// Single event counter with clear, sticky overflow, and wrap or saturate on overflow.
// Saturation is selected by defining PERF_SAT_EN; otherwise the counter wraps.
module perf_ctr #(
   parameter int unsigned CNT_W = 64,
   parameter int unsigned INC_W = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             en,
   input  logic [INC_W-1:0] inc,
   output logic [CNT_W-1:0] cnt,
   output logic             ovf
);
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ovf_q, ovf_d;
   logic [CNT_W:0]   sum;

   always_comb begin
      sum   = {1'b0, cnt_q} + (CNT_W+1)'(inc);
      cnt_d = cnt_q;
      ovf_d = ovf_q;
      if (clr) begin
         cnt_d = '0;
         ovf_d = 1'b0;
      end else if (en) begin
         cnt_d = sum[CNT_W-1:0];
         if (sum[CNT_W]) begin
            ovf_d = 1'b1;
`ifdef PERF_SAT_EN
            cnt_d = '1;
`else
            cnt_d = sum[CNT_W-1:0];
`endif
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         ovf_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         ovf_q <= ovf_d;
      end
   end

   assign cnt = cnt_q;
   assign ovf = ovf_q;
endmodule

// File: rtl/perf_counter_unit.sv
// Performance-monitor top: per-event increments, shadow snapshot bank and registered read port.
// Overflow behaviour of the counters follows PERF_SAT_EN (see perf_ctr).
module perf_counter_unit
   import perf_pkg::*;
#(
   parameter int unsigned LANES = 2,
   parameter int unsigned CNT_W = 64
) (
   input  logic                clk,
   input  logic                Reset,
   input  logic                count_en,
   input  logic                clear,
   input  logic [LANES-1:0]    inst_valid,
   input  logic [LANES-1:0]    branch_ex,
   input  logic [LANES-1:0]    false_taken,
   input  logic [LANES-1:0]    false_not_taken,
   input  logic                flush,
   input  logic                stall,
   input  logic                snap_req,
   input  logic                rd_en,
   input  logic [RD_SEL_W-1:0] rd_sel,
   output logic [CNT_W-1:0]    rd_data,
   output logic                rd_valid,
   output logic [NUM_EV-1:0]   ovf,
   output logic                snap_valid
);
   localparam int unsigned INC_W = $clog2(LANES + 1);

   logic [INC_W-1:0] inc [NUM_EV];
   logic [CNT_W-1:0] cnt [NUM_EV];
   logic [LANES-1:0] mispred;

   logic [CNT_W-1:0] shadow_q [NUM_EV];
   logic [CNT_W-1:0] shadow_d [NUM_EV];
   logic [CNT_W-1:0] rd_data_q, rd_data_d;
   logic             rd_valid_q, rd_valid_d;
   logic             snap_valid_q, snap_valid_d;

   always_comb begin
      mispred         = branch_ex & (false_taken | false_not_taken);
      inc[EV_CYCLES]  = INC_W'(1);
      inc[EV_INSTS]   = INC_W'(popcount(MAX_LANES'(inst_valid)));
      inc[EV_BRANCH]  = INC_W'(popcount(MAX_LANES'(branch_ex)));
      inc[EV_MISPRED] = INC_W'(popcount(MAX_LANES'(mispred)));
      inc[EV_FLUSH]   = INC_W'(flush);
      inc[EV_STALLS]  = INC_W'(stall);
   end

   for (genvar k = 0; k < NUM_EV; k++) begin : g_ctr
      perf_ctr #(
         .CNT_W (CNT_W),
         .INC_W (INC_W)
      ) u_ctr (
         .clk (clk),
         .rst (Reset),
         .clr (clear),
         .en  (count_en),
         .inc (inc[k]),
         .cnt (cnt[k]),
         .ovf (ovf[k])
      );
   end

   // Reads use the registered shadow, so a same-edge snapshot is not visible yet.
   always_comb begin
      shadow_d     = shadow_q;
      rd_data_d    = rd_data_q;
      rd_valid_d   = rd_en;
      snap_valid_d = snap_valid_q | snap_req;
      if (snap_req) begin
         for (int unsigned k = 0; k < NUM_EV; k++) begin
            shadow_d[k] = cnt[k];
         end
      end
      if (rd_en) begin
         rd_data_d = '0;
         for (int unsigned k = 0; k < NUM_EV; k++) begin
            if (rd_sel == RD_SEL_W'(k)) begin
               rd_data_d = shadow_q[k];
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (Reset) begin
         shadow_q     <= '{default: '0};
         rd_data_q    <= '0;
         rd_valid_q   <= 1'b0;
         snap_valid_q <= 1'b0;
      end else begin
         shadow_q     <= shadow_d;
         rd_data_q    <= rd_data_d;
         rd_valid_q   <= rd_valid_d;
         snap_valid_q <= snap_valid_d;
      end
   end

   assign rd_data    = rd_data_q;
   assign rd_valid   = rd_valid_q;
   assign snap_valid = snap_valid_q;
endmodule

// File: tb/tb_perf_counter_unit.sv
// Directed self-checking bench for perf_counter_unit (64-bit default instance plus an 8-bit overflow instance).
module tb_perf_counter_unit;
   logic       clk = 1'b0;
   logic       Reset, count_en, clear, flush, stall, snap_req, rd_en;
   logic [1:0] inst_valid, branch_ex, false_taken, false_not_taken;
   logic [2:0] rd_sel;

   logic [63:0] rd_data;
   logic        rd_valid, snap_valid;
   logic [5:0]  ovf;
   logic [7:0]  rd_data8;
   logic        rd_valid8, snap_valid8;
   logic [5:0]  ovf8;

   int unsigned checks = 0;
   int unsigned errors = 0;

   always #5 clk = ~clk;

   perf_counter_unit dut (
      .clk(clk), .Reset(Reset), .count_en(count_en), .clear(clear),
      .inst_valid(inst_valid), .branch_ex(branch_ex), .false_taken(false_taken),
      .false_not_taken(false_not_taken), .flush(flush), .stall(stall),
      .snap_req(snap_req), .rd_en(rd_en), .rd_sel(rd_sel),
      .rd_data(rd_data), .rd_valid(rd_valid), .ovf(ovf), .snap_valid(snap_valid)
   );

   perf_counter_unit #(.LANES(2), .CNT_W(8)) dut8 (
      .clk(clk), .Reset(Reset), .count_en(count_en), .clear(clear),
      .inst_valid(inst_valid), .branch_ex(branch_ex), .false_taken(false_taken),
      .false_not_taken(false_not_taken), .flush(flush), .stall(stall),
      .snap_req(snap_req), .rd_en(rd_en), .rd_sel(rd_sel),
      .rd_data(rd_data8), .rd_valid(rd_valid8), .ovf(ovf8), .snap_valid(snap_valid8)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // advance one clock; inputs change and outputs are sampled 1ns after the edge
   task automatic step(input int unsigned n = 1);
      for (int unsigned i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic snap();
      snap_req = 1'b1;
      step();
      snap_req = 1'b0;
   endtask

   task automatic rd(input logic [2:0] sel, input string tag, input logic [63:0] exp);
      rd_en  = 1'b1;
      rd_sel = sel;
      step();
      rd_en  = 1'b0;
      check({tag, "_valid"}, 64'(rd_valid), 64'd1);
      check(tag, rd_data, exp);
   endtask

   task automatic do_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   initial begin
      Reset = 1'b1; count_en = 1'b0; clear = 1'b0; flush = 1'b0; stall = 1'b0;
      snap_req = 1'b0; rd_en = 1'b0; rd_sel = '0;
      inst_valid = '0; branch_ex = '0; false_taken = '0; false_not_taken = '0;
      step(2);
      Reset = 1'b0;
      step();
      check("rst_rd_valid", 64'(rd_valid), 64'd0);
      check("rst_rd_data", rd_data, 64'd0);
      check("rst_ovf", 64'(ovf), 64'd0);
      check("rst_snap_valid", 64'(snap_valid), 64'd0);

      // 10 counting cycles, no events; counters must hold once count_en drops
      count_en = 1'b1;
      step(10);
      count_en = 1'b0;
      step(3);
      snap();
      check("snap_valid", 64'(snap_valid), 64'd1);
      rd(3'd0, "cycles10", 64'd10);
      for (int i = 1; i < 6; i++) rd(3'(i), "zero_ev", 64'd0);
      step();
      check("rd_valid_drop", 64'(rd_valid), 64'd0);
      check("rd_data_hold", rd_data, 64'd0);

      // instructions: 2+2+2+1+1
      do_clear();
      count_en = 1'b1;
      inst_valid = 2'b11; step(3);
      inst_valid = 2'b01; step(2);
      inst_valid = 2'b00; count_en = 1'b0;
      snap();
      rd(3'd1, "insts", 64'd8);
      rd(3'd0, "cycles5", 64'd5);
      step();
      check("rd_data_hold5", rd_data, 64'd5);

      // branches and mispredicts; mispredict bits without branch_ex ignored
      do_clear();
      count_en = 1'b1;
      branch_ex = 2'b10; false_taken = 2'b11; step(4);
      branch_ex = 2'b00; false_taken = 2'b01; step(2);
      false_taken = 2'b00; false_not_taken = 2'b01; branch_ex = 2'b01; flush = 1'b1; step(1);
      branch_ex = 2'b00; false_not_taken = 2'b00; flush = 1'b0;
      count_en = 1'b0;
      snap();
      rd(3'd2, "branches", 64'd5);
      rd(3'd3, "mispred", 64'd5);
      rd(3'd4, "flushes", 64'd1);

      // overflow on the 8-bit instance: 260 cycles of stall
      do_clear();
      count_en = 1'b1; stall = 1'b1;
      step(260);
      count_en = 1'b0; stall = 1'b0;
      check("ovf8", 64'(ovf8), 64'b100001);
      check("ovf64", 64'(ovf), 64'd0);
      snap();
      rd(3'd5, "stalls64", 64'd260);
`ifdef PERF_SAT_EN
      check("stalls8", 64'(rd_data8), 64'd255);
`else
      check("stalls8", 64'(rd_data8), 64'd4);
`endif

      // clear + snapshot + read in the same cycle
      do_clear();
      check("ovf8_cleared", 64'(ovf8), 64'd0);
      count_en = 1'b1; stall = 1'b1;
      step(50);
      count_en = 1'b0; stall = 1'b0;
      clear = 1'b1; snap_req = 1'b1; rd_en = 1'b1; rd_sel = 3'd0;
      step();
      clear = 1'b0; snap_req = 1'b0; rd_en = 1'b0;
      check("pre_snap_read", rd_data, 64'd260);
      rd(3'd0, "shadow_pre_clear", 64'd50);
      rd(3'd7, "sel7", 64'd0);
      snap();
      rd(3'd0, "live_after_clear", 64'd0);

      // Reset during a pending read
      count_en = 1'b1; step(7); count_en = 1'b0;
      snap();
      rd(3'd0, "cycles7", 64'd7);
      rd_en = 1'b1; rd_sel = 3'd0; Reset = 1'b1;
      step();
      rd_en = 1'b0; Reset = 1'b0;
      check("rst_mid_valid", 64'(rd_valid), 64'd0);
      check("rst_mid_data", rd_data, 64'd0);
      check("rst_mid_snap_valid", 64'(snap_valid), 64'd0);
      rd(3'd0, "shadow_after_rst", 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
